// File: rtl/store_narrow_unit.sv
// Narrows a 32-bit store onto a 16-bit memory write port: a word becomes two halfword beats, a halfword one beat with truncation check.
// Optional macro STORE_NARROW_BIG_ENDIAN_EN: word stores emit the high half first.
module store_narrow_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned HALF_STEP = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic              req_size,
  input  logic              ExtSel,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              done,
  output logic              trunc_err,
  output logic              align_err
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_data;
  logic              r_word;
  logic              r_ext;
  logic              r_trunc;
  logic              r_align;

  logic              w_accept;
  logic              w_lo_done;
  logic              w_trunc;
  logic [15:0]       w_first;
  logic [15:0]       w_second;
  logic [ADDR_W-1:0] w_hi_addr;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_lo_done = (r_state == S_LO) && mem_ready;
  assign w_hi_addr = r_base + ADDR_W'(HALF_STEP);

  // Inverse of sign/zero extension: the upper half must be pure extension of the lower.
  assign w_trunc = r_ext ? (r_data[31:16] != {16{r_data[15]}})
                         : (r_data[31:16] != 16'h0000);

`ifdef STORE_NARROW_BIG_ENDIAN_EN
  assign w_first  = r_word ? r_data[31:16] : r_data[15:0];
  assign w_second = r_data[15:0];
`else
  assign w_first  = r_data[15:0];
  assign w_second = r_data[31:16];
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = req_addr[0] ? S_DONE : S_LO;
      S_LO:   if (mem_ready) w_next = r_word ? S_HI : S_DONE;
      S_HI:   if (mem_ready) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_LO: begin
        mem_valid = 1'b1;
        mem_addr  = r_base;
        mem_wdata = w_first;
      end
      S_HI: begin
        mem_valid = 1'b1;
        mem_addr  = w_hi_addr;
        mem_wdata = w_second;
      end
      S_DONE: done = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // Error flags clear on accept and are set as the request completes, so they hold from done onward.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_base  <= '0;
      r_data  <= '0;
      r_word  <= 1'b0;
      r_ext   <= 1'b0;
      r_trunc <= 1'b0;
      r_align <= 1'b0;
    end else if (w_accept) begin
      r_base  <= req_addr;
      r_data  <= req_data;
      r_word  <= req_size;
      r_ext   <= ExtSel;
      r_align <= req_addr[0];
      r_trunc <= 1'b0;
    end else if (w_lo_done && !r_word) begin
      r_trunc <= w_trunc;
    end
  end

  assign trunc_err = r_trunc;
  assign align_err = r_align;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Randomized self-checking bench for store_narrow_unit against an arithmetic reference model.
module tb_store_narrow_unit;
  localparam int unsigned AW = 32;
  localparam int unsigned HS = 2;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic          req_size;
  logic          ExtSel;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          done;
  logic          trunc_err;
  logic          align_err;

  int checks = 0;
  int failures = 0;

  store_narrow_unit #(.ADDR_W(AW), .HALF_STEP(HS)) dut (
    .CLK(CLK), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size), .ExtSel(ExtSel),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .done(done), .trunc_err(trunc_err), .align_err(align_err)
  );

  always #5 CLK = ~CLK;

  // Observations of the most recent transaction
  logic [AW-1:0] ob_addr[$];
  logic [15:0]   ob_data[$];
  int            ob_lat;
  logic          ob_trunc, ob_align, ob_timeout, ob_stable, ob_ready_ok, ob_hold_ok;

  // Reference: what memory should see, computed from the store rules directly.
  function automatic void model(input logic [AW-1:0] a, input logic [31:0] d, input logic sz,
                                input logic ext, input int st0, input int st1,
                                output int nb, output logic [1:0][AW-1:0] ea,
                                output logic [1:0][15:0] ed, output logic et,
                                output logic eal, output int lat);
    longint sv;
    ea = '0; ed = '0; et = 1'b0; eal = a[0];
    if (eal) begin
      nb = 0; lat = 1;
    end else begin
      nb = sz ? 2 : 1;
      ea[0] = a;
      ea[1] = a + AW'(HS);
      if (sz) begin
`ifdef STORE_NARROW_BIG_ENDIAN_EN
        ed[0] = 16'(d >> 16); ed[1] = 16'(d);
`else
        ed[0] = 16'(d); ed[1] = 16'(d >> 16);
`endif
      end else begin
        ed[0] = 16'(d);
        sv = longint'($signed(d));
        et = ext ? (sv < -32768 || sv > 32767) : (d > 32'd65535);
      end
      lat = 1 + nb + st0 + (sz ? st1 : 0);
    end
  endfunction

  task automatic run_txn(input logic [AW-1:0] a, input logic [31:0] d, input logic sz,
                         input logic ext, input int st0, input int st1);
    int n, beat, stall;
    logic [AW-1:0] ha;
    logic [15:0]   hd;
    ob_addr.delete(); ob_data.delete();
    ob_lat = -1; ob_timeout = 1'b0; ob_stable = 1'b1; ob_trunc = 1'b0; ob_align = 1'b0;
    ha = '0; hd = '0;
    @(negedge CLK);
    ob_ready_ok = (req_ready === 1'b1);
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz; ExtSel = ext; mem_ready = 1'b0;
    @(negedge CLK);
    req_valid = 1'b0; req_addr = $urandom; req_data = $urandom;
    req_size = 1'($urandom); ExtSel = 1'($urandom);
    n = 1; beat = 0; stall = 0;
    while (ob_lat < 0 && n <= 20) begin
      if (mem_valid === 1'b1) begin
        if (stall > 0 && (mem_addr !== ha || mem_wdata !== hd)) ob_stable = 1'b0;
        ha = mem_addr; hd = mem_wdata;
        if (stall < (beat == 0 ? st0 : st1)) begin
          stall++; mem_ready = 1'b0;
        end else begin
          ob_addr.push_back(mem_addr); ob_data.push_back(mem_wdata);
          mem_ready = 1'b1; beat++; stall = 0;
        end
      end else begin
        mem_ready = 1'($urandom);
      end
      if (done === 1'b1) begin
        ob_lat = n; ob_trunc = trunc_err; ob_align = align_err;
      end else begin
        @(negedge CLK); n++;
      end
    end
    if (ob_lat < 0) ob_timeout = 1'b1;
    @(negedge CLK);
    ob_hold_ok = (done === 1'b0 && trunc_err === ob_trunc && align_err === ob_align && req_ready === 1'b1);
    mem_ready = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = 1'b0;
    ExtSel = 1'b0; mem_ready = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({req_ready, mem_valid, done, trunc_err, align_err} !== 5'b10000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=10000", {req_ready, mem_valid, done, trunc_err, align_err});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      failures++; $display("FAIL reset_bus got addr=%h data=%h exp 0/0", mem_addr, mem_wdata);
    end
    Reset = 1'b1;
  endtask

  task automatic test_word;
    int nb, lat; logic [1:0][AW-1:0] ea; logic [1:0][15:0] ed; logic et, eal;
    run_txn(32'h0000_0010, 32'h1234_ABCD, 1'b1, 1'b0, 0, 0);
    model(32'h0000_0010, 32'h1234_ABCD, 1'b1, 1'b0, 0, 0, nb, ea, ed, et, eal, lat);
    checks++;
    if (ob_timeout || ob_lat != lat) begin failures++; $display("FAIL word_latency got=%0d exp=%0d", ob_lat, lat); end
    checks++;
    if (ob_addr.size() != nb) begin failures++; $display("FAIL word_beats got=%0d exp=%0d", ob_addr.size(), nb); end
    for (int i = 0; i < nb && i < ob_addr.size(); i++) begin
      checks++;
      if (ob_addr[i] !== ea[i] || ob_data[i] !== ed[i]) begin
        failures++; $display("FAIL word_beat%0d got=%h/%h exp=%h/%h", i, ob_addr[i], ob_data[i], ea[i], ed[i]);
      end
    end
    checks++;
    if ({ob_trunc, ob_align, ob_ready_ok, ob_hold_ok} !== {et, eal, 2'b11}) begin
      failures++; $display("FAIL word_flags got=%b exp=%b", {ob_trunc, ob_align, ob_ready_ok, ob_hold_ok}, {et, eal, 2'b11});
    end
  endtask

  task automatic test_halfword;
    logic [31:0] tdata[4];
    logic        text[4];
    int nb, lat; logic [1:0][AW-1:0] ea; logic [1:0][15:0] ed; logic et, eal;
    tdata[0] = 32'hFFFF_8001; text[0] = 1'b1;
    tdata[1] = 32'h0000_8001; text[1] = 1'b1;
    tdata[2] = 32'h0001_0005; text[2] = 1'b0;
    tdata[3] = 32'h0000_FFFF; text[3] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      run_txn(32'h0000_0200, tdata[t], 1'b0, text[t], 0, 0);
      model(32'h0000_0200, tdata[t], 1'b0, text[t], 0, 0, nb, ea, ed, et, eal, lat);
      checks++;
      if (ob_timeout || ob_lat != lat || ob_addr.size() != nb) begin
        failures++; $display("FAIL half%0d_shape got lat=%0d beats=%0d exp lat=%0d beats=%0d", t, ob_lat, ob_addr.size(), lat, nb);
      end else if (ob_addr[0] !== ea[0] || ob_data[0] !== ed[0]) begin
        failures++; $display("FAIL half%0d_beat got=%h/%h exp=%h/%h", t, ob_addr[0], ob_data[0], ea[0], ed[0]);
      end
      checks++;
      if ({ob_trunc, ob_align, ob_hold_ok} !== {et, eal, 1'b1}) begin
        failures++; $display("FAIL half%0d_flags got=%b exp=%b", t, {ob_trunc, ob_align, ob_hold_ok}, {et, eal, 1'b1});
      end
    end
  endtask

  task automatic test_misaligned;
    run_txn(32'h0000_0003, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 0);
    checks++;
    if (ob_timeout || ob_lat != 1 || ob_addr.size() != 0) begin
      failures++; $display("FAIL misaligned_shape got lat=%0d beats=%0d exp lat=1 beats=0", ob_lat, ob_addr.size());
    end
    checks++;
    if ({ob_align, ob_trunc, ob_hold_ok} !== 3'b101) begin
      failures++; $display("FAIL misaligned_flags got=%b exp=101", {ob_align, ob_trunc, ob_hold_ok});
    end
  endtask

  task automatic test_stall_wrap;
    int nb, lat; logic [1:0][AW-1:0] ea; logic [1:0][15:0] ed; logic et, eal;
    run_txn(32'hFFFF_FFFE, 32'hCAFE_0042, 1'b1, 1'b0, 3, 0);
    model(32'hFFFF_FFFE, 32'hCAFE_0042, 1'b1, 1'b0, 3, 0, nb, ea, ed, et, eal, lat);
    checks++;
    if (ob_timeout || ob_lat != lat) begin failures++; $display("FAIL stall_latency got=%0d exp=%0d", ob_lat, lat); end
    checks++;
    if (!ob_stable) begin failures++; $display("FAIL stall_stable got=0 exp=1"); end
    checks++;
    if (ob_addr.size() != 2 || ob_addr[1] !== ea[1] || ob_data[1] !== ed[1]) begin
      failures++; $display("FAIL stall_wrap_beat got n=%0d exp addr=%h data=%h", ob_addr.size(), ea[1], ed[1]);
    end
  endtask

  task automatic test_reset_mid;
    logic seen_done;
    int nb, lat; logic [1:0][AW-1:0] ea; logic [1:0][15:0] ed; logic et, eal;
    @(negedge CLK);
    req_valid = 1'b1; req_addr = 32'h0000_0100; req_data = 32'h5555_AAAA; req_size = 1'b1; mem_ready = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    @(posedge CLK); #2;
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_0102) begin
      failures++; $display("FAIL rstmid_in_hi got valid=%b addr=%h exp 1/00000102", mem_valid, mem_addr);
    end
    Reset = 1'b0; #1;
    checks++;
    if (mem_valid !== 1'b0) begin failures++; $display("FAIL rstmid_async got=%b exp=0", mem_valid); end
    seen_done = 1'b0;
    repeat (3) begin @(negedge CLK); if (done === 1'b1) seen_done = 1'b1; end
    Reset = 1'b1; mem_ready = 1'b0;
    @(negedge CLK);
    checks++;
    if (seen_done !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_after got done_seen=%b ready=%b exp 0/1", seen_done, req_ready);
    end
    run_txn(32'h0000_0040, 32'hFFFF_FFFE, 1'b0, 1'b1, 1, 0);
    model(32'h0000_0040, 32'hFFFF_FFFE, 1'b0, 1'b1, 1, 0, nb, ea, ed, et, eal, lat);
    checks++;
    if (ob_timeout || ob_lat != lat || ob_addr.size() != 1 || ob_data[0] !== ed[0] || ob_trunc !== et) begin
      failures++; $display("FAIL rstmid_next got lat=%0d n=%0d trunc=%b exp lat=%0d data=%h trunc=%b", ob_lat, ob_addr.size(), ob_trunc, lat, ed[0], et);
    end
  endtask

  task automatic test_random;
    logic [AW-1:0] a; logic [31:0] d; logic sz, ext; int st0, st1;
    int nb, lat; logic [1:0][AW-1:0] ea; logic [1:0][15:0] ed; logic et, eal; logic ok;
    for (int it = 0; it < 40; it++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      case ($urandom_range(0, 2))
        0: d = $urandom;
        1: d = 32'(signed'(16'($urandom)));
        default: d = {16'h0000, 16'($urandom)};
      endcase
      sz = 1'($urandom); ext = 1'($urandom);
      st0 = $urandom_range(0, 2); st1 = $urandom_range(0, 2);
      run_txn(a, d, sz, ext, st0, st1);
      model(a, d, sz, ext, st0, st1, nb, ea, ed, et, eal, lat);
      ok = !ob_timeout && ob_lat == lat && ob_addr.size() == nb && ob_stable && ob_hold_ok && ob_ready_ok
           && ob_trunc === et && ob_align === eal;
      for (int i = 0; i < nb && i < ob_addr.size(); i++)
        if (ob_addr[i] !== ea[i] || ob_data[i] !== ed[i]) ok = 1'b0;
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rand%0d a=%h d=%h sz=%b ext=%b got lat=%0d n=%0d te=%b ae=%b exp lat=%0d n=%0d te=%b ae=%b",
                 it, a, d, sz, ext, ob_lat, ob_addr.size(), ob_trunc, ob_align, lat, nb, et, eal);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_halfword();
    test_misaligned();
    test_stall_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
